// File: rtl/taillight_decoder.sv
// Tail-light sequence decoder: follows the walking L1-L2-L3 / R1-R2-R3 lamp patterns,
// counts completed sequences and flags ordering, hold-time and illegal-pattern violations.
module taillight_decoder #(
    parameter int HOLD_MAX = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             la,
    input  logic             lb,
    input  logic             lc,
    input  logic             ra,
    input  logic             rb,
    input  logic             rc,
    output logic             left_on,
    output logic             right_on,
    output logic             err,
    output logic             err_pulse,
    output logic [CNT_W-1:0] left_cnt,
    output logic [CNT_W-1:0] right_cnt,
    output logic [2:0]       state_o
);

    // hold_r counts repeats after entering a state, so it never exceeds HOLD_MAX-1
    localparam int HOLD_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S_L1  = 3'd1,
        S_L2  = 3'd2,
        S_L3  = 3'd3,
        S_R1  = 3'd4,
        S_R2  = 3'd5,
        S_R3  = 3'd6,
        S_ERR = 3'd7
    } state_e;

    localparam logic [2:0] C_OFF = 3'd0;
    localparam logic [2:0] C_L1  = 3'd1;
    localparam logic [2:0] C_R1  = 3'd4;

    function automatic logic [2:0] classify(input logic [5:0] lamps);
        logic [2:0] cls;
        case (lamps)
            6'b000000: cls = 3'd0;
            6'b100000: cls = 3'd1;
            6'b110000: cls = 3'd2;
            6'b111000: cls = 3'd3;
            6'b000100: cls = 3'd4;
            6'b000110: cls = 3'd5;
            6'b000111: cls = 3'd6;
            default:   cls = 3'd7;
        endcase
        return cls;
    endfunction

    state_e            state_r;
    state_e            nxt_state_s;
    logic [HOLD_W-1:0] hold_r;
    logic [HOLD_W-1:0] nxt_hold_s;
    logic [2:0]        cls_s;
    logic              rep_ok_s;
    logic              viol_s;
    logic              inc_l_s;
    logic              inc_r_s;
    logic              left_on_r;
    logic              right_on_r;
    logic              err_r;
    logic              err_pulse_r;
    logic [CNT_W-1:0]  left_cnt_r;
    logic [CNT_W-1:0]  right_cnt_r;

    // Sample classes share the numbering of the states they lead into
    assign cls_s    = classify({la, lb, lc, ra, rb, rc});
    assign rep_ok_s = (hold_r < HOLD_W'(HOLD_MAX - 1));

    // Next-state, hold-counter and event decode for one enabled sample
    always_comb begin
        nxt_state_s = state_r;
        nxt_hold_s  = hold_r;
        viol_s      = 1'b0;
        inc_l_s     = 1'b0;
        inc_r_s     = 1'b0;
        if (en) begin
            case (state_r)
                IDLE: begin
                    nxt_hold_s = '0;
                    if (cls_s == C_L1) begin
                        nxt_state_s = S_L1;
                    end else if (cls_s == C_R1) begin
                        nxt_state_s = S_R1;
                    end else if (cls_s != C_OFF) begin
                        viol_s = 1'b1;
                    end else begin
                        nxt_state_s = IDLE;
                    end
                end
                S_L1, S_L2, S_R1, S_R2: begin
                    if (cls_s == 3'(state_r)) begin
                        if (rep_ok_s) begin
                            nxt_hold_s = hold_r + HOLD_W'(1);
                        end else begin
                            viol_s = 1'b1;
                        end
                    end else if (cls_s == 3'(state_r) + 3'd1) begin
                        nxt_state_s = state_e'(cls_s);
                        nxt_hold_s  = '0;
                    end else begin
                        viol_s = 1'b1;
                    end
                end
                S_L3, S_R3: begin
                    if (cls_s == 3'(state_r)) begin
                        if (rep_ok_s) begin
                            nxt_hold_s = hold_r + HOLD_W'(1);
                        end else begin
                            viol_s = 1'b1;
                        end
                    end else if (cls_s == C_OFF) begin
                        nxt_state_s = IDLE;
                        nxt_hold_s  = '0;
                        inc_l_s     = (state_r == S_L3);
                        inc_r_s     = (state_r == S_R3);
                    end else begin
                        viol_s = 1'b1;
                    end
                end
                S_ERR: begin
                    nxt_hold_s = '0;
                    if (cls_s == C_OFF) begin
                        nxt_state_s = IDLE;
                    end else begin
                        nxt_state_s = S_ERR;
                    end
                end
                default: begin
                    nxt_state_s = IDLE;
                    nxt_hold_s  = '0;
                end
            endcase
            if (viol_s) begin
                nxt_state_s = S_ERR;
                nxt_hold_s  = '0;
            end else begin
                nxt_hold_s = nxt_hold_s;
            end
        end else begin
            nxt_state_s = state_r;
        end
    end

    // State, hold counter and the registered state-derived outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            hold_r      <= '0;
            left_on_r   <= 1'b0;
            right_on_r  <= 1'b0;
            err_pulse_r <= 1'b0;
        end else begin
            state_r     <= nxt_state_s;
            hold_r      <= nxt_hold_s;
            left_on_r   <= (nxt_state_s == S_L1) || (nxt_state_s == S_L2) || (nxt_state_s == S_L3);
            right_on_r  <= (nxt_state_s == S_R1) || (nxt_state_s == S_R2) || (nxt_state_s == S_R3);
            err_pulse_r <= viol_s;
        end
    end

    // Sticky error and saturating sequence counters; a violation beats clr, clr beats an increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r       <= 1'b0;
            left_cnt_r  <= '0;
            right_cnt_r <= '0;
        end else begin
            if (viol_s) begin
                err_r <= 1'b1;
            end else if (clr) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
            if (clr) begin
                left_cnt_r <= '0;
            end else if (inc_l_s && (left_cnt_r != {CNT_W{1'b1}})) begin
                left_cnt_r <= left_cnt_r + CNT_W'(1);
            end else begin
                left_cnt_r <= left_cnt_r;
            end
            if (clr) begin
                right_cnt_r <= '0;
            end else if (inc_r_s && (right_cnt_r != {CNT_W{1'b1}})) begin
                right_cnt_r <= right_cnt_r + CNT_W'(1);
            end else begin
                right_cnt_r <= right_cnt_r;
            end
        end
    end

    assign state_o   = state_r;
    assign left_on   = left_on_r;
    assign right_on  = right_on_r;
    assign err       = err_r;
    assign err_pulse = err_pulse_r;
    assign left_cnt  = left_cnt_r;
    assign right_cnt = right_cnt_r;

endmodule

// File: tb/tb_taillight_decoder.sv
// Self-checking bench for taillight_decoder: directed scenarios plus biased random
// lamp sequences compared every cycle against a sequence-level reference model.
module tb_taillight_decoder;

    localparam int HOLD_MAX = 3;
    localparam logic [5:0] P_OFF = 6'b000000;
    localparam logic [5:0] P_L1  = 6'b100000;
    localparam logic [5:0] P_L2  = 6'b110000;
    localparam logic [5:0] P_L3  = 6'b111000;
    localparam logic [5:0] P_R1  = 6'b000100;
    localparam logic [5:0] P_R2  = 6'b000110;
    localparam logic [5:0] P_R3  = 6'b000111;
    localparam logic [5:0] P_LR  = 6'b100100;

    logic       clk = 1'b0;
    logic       reset, en, clr, la, lb, lc, ra, rb, rc;
    logic       left_on, right_on, err, err_pulse;
    logic [7:0] left_cnt, right_cnt;
    logic [2:0] state_o;
    logic       b_left_on, b_right_on, b_err, b_err_pulse;
    logic [1:0] b_left_cnt, b_right_cnt;
    logic [2:0] b_state_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // model: mode 0 idle, 1 in sequence, 2 error; side 1 left, 2 right; step 1..3; run = consecutive samples
    int m_mode, m_side, m_step, m_run, m_lcnt, m_rcnt;
    bit m_err, m_pulse;

    taillight_decoder #(.HOLD_MAX(HOLD_MAX), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr),
        .la(la), .lb(lb), .lc(lc), .ra(ra), .rb(rb), .rc(rc),
        .left_on(left_on), .right_on(right_on), .err(err), .err_pulse(err_pulse),
        .left_cnt(left_cnt), .right_cnt(right_cnt), .state_o(state_o)
    );

    taillight_decoder #(.HOLD_MAX(HOLD_MAX), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .clr(clr),
        .la(la), .lb(lb), .lc(lc), .ra(ra), .rb(rb), .rc(rc),
        .left_on(b_left_on), .right_on(b_right_on), .err(b_err), .err_pulse(b_err_pulse),
        .left_cnt(b_left_cnt), .right_cnt(b_right_cnt), .state_o(b_state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int exp_state();
        if (m_mode == 0) return 0;
        else if (m_mode == 2) return 7;
        else return (m_side == 1) ? m_step : 3 + m_step;
    endfunction

    function automatic logic [5:0] lvl_pat(input int side, input int lv);
        logic [2:0] t;
        t = (lv == 0) ? 3'b000 : (lv == 1) ? 3'b100 : (lv == 2) ? 3'b110 : 3'b111;
        return (side == 1) ? {t, 3'b000} : {3'b000, t};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_side = 0; m_step = 0; m_run = 0;
        m_lcnt = 0; m_rcnt = 0; m_err = 1'b0; m_pulse = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic c, input logic [5:0] p);
        int nl, nr, lv, side;
        bit bad, viol;
        viol = 1'b0;
        m_pulse = 1'b0;
        if (e) begin
            nl   = int'(p[5]) + int'(p[4]) + int'(p[3]);
            nr   = int'(p[2]) + int'(p[1]) + int'(p[0]);
            bad  = (nl > 0 && nr > 0) || !(p[5] >= p[4] && p[4] >= p[3]) ||
                   !(p[2] >= p[1] && p[1] >= p[0]);
            side = (nl > 0) ? 1 : ((nr > 0) ? 2 : 0);
            lv   = nl + nr;
            case (m_mode)
                0: begin
                    if (lv == 0) begin
                        m_mode = 0;
                    end else if (!bad && lv == 1) begin
                        m_mode = 1; m_side = side; m_step = 1; m_run = 1;
                    end else begin
                        viol = 1'b1;
                    end
                end
                1: begin
                    if (!bad && side == m_side && lv == m_step) begin
                        if (m_run + 1 > HOLD_MAX) viol = 1'b1;
                        else m_run++;
                    end else if (!bad && m_step < 3 && side == m_side && lv == m_step + 1) begin
                        m_step++; m_run = 1;
                    end else if (m_step == 3 && lv == 0) begin
                        m_mode = 0;
                        if (m_side == 1) m_lcnt++;
                        else m_rcnt++;
                    end else begin
                        viol = 1'b1;
                    end
                end
                default: begin
                    if (lv == 0) m_mode = 0;
                end
            endcase
            if (viol) begin
                m_mode = 2; m_pulse = 1'b1;
            end
        end
        if (c) begin
            m_lcnt = 0; m_rcnt = 0; m_err = 1'b0;
        end
        if (viol) m_err = 1'b1;
    endtask

    task automatic cyc(input logic e, input logic c, input logic [5:0] p);
        en = e; clr = c;
        {la, lb, lc, ra, rb, rc} = p;
        @(posedge clk);
        model_step(e, c, p);
        @(negedge clk);
    endtask

    task automatic left_seq();
        cyc(1'b1, 1'b0, P_L1); cyc(1'b1, 1'b0, P_L2);
        cyc(1'b1, 1'b0, P_L3); cyc(1'b1, 1'b0, P_OFF);
    endtask

    // Every-cycle comparison of both instances against the reference model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("state_o",     int'(state_o),     exp_state());
            chk("left_on",     int'(left_on),     int'(m_mode == 1 && m_side == 1));
            chk("right_on",    int'(right_on),    int'(m_mode == 1 && m_side == 2));
            chk("err",         int'(err),         int'(m_err));
            chk("err_pulse",   int'(err_pulse),   int'(m_pulse));
            chk("left_cnt",    int'(left_cnt),    sat(m_lcnt, 255));
            chk("right_cnt",   int'(right_cnt),   sat(m_rcnt, 255));
            chk("w2_state_o",  int'(b_state_o),   exp_state());
            chk("w2_left_cnt", int'(b_left_cnt),  sat(m_lcnt, 3));
            chk("w2_right_cnt", int'(b_right_cnt), sat(m_rcnt, 3));
        end
    end

    initial begin
        logic [5:0] prev, p;
        int r, lon;
        reset = 1'b1; en = 1'b0; clr = 1'b0;
        {la, lb, lc, ra, rb, rc} = 6'b000000;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_state", int'(state_o), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_cnt", int'(left_cnt) + int'(right_cnt), 0);
        reset = 1'b0;
        chk_on = 1'b1;

        // basic left sequence
        lon = 0;
        cyc(1'b1, 1'b0, P_OFF); chk("s34_st0", int'(state_o), 0); lon += int'(left_on);
        cyc(1'b1, 1'b0, P_L1);  chk("s34_st1", int'(state_o), 1); lon += int'(left_on);
        cyc(1'b1, 1'b0, P_L2);  chk("s34_st2", int'(state_o), 2); lon += int'(left_on);
        cyc(1'b1, 1'b0, P_L3);  chk("s34_st3", int'(state_o), 3); lon += int'(left_on);
        cyc(1'b1, 1'b0, P_OFF); chk("s34_st4", int'(state_o), 0); lon += int'(left_on);
        chk("s34_lon_cycles", lon, 3);
        chk("s34_lcnt", int'(left_cnt), 1);
        chk("s34_err", int'(err), 0);

        // right sequence with allowed holds, then hold overrun
        cyc(1'b1, 1'b0, P_R1); cyc(1'b1, 1'b0, P_R1); cyc(1'b1, 1'b0, P_R1);
        cyc(1'b1, 1'b0, P_R2); cyc(1'b1, 1'b0, P_R3); cyc(1'b1, 1'b0, P_OFF);
        chk("s35_err", int'(err), 0);
        chk("s35_rcnt", int'(right_cnt), 1);
        cyc(1'b1, 1'b0, P_R1); cyc(1'b1, 1'b0, P_R1); cyc(1'b1, 1'b0, P_R1);
        chk("s35_pulse3", int'(err_pulse), 0);
        cyc(1'b1, 1'b0, P_R1);
        chk("s35_pulse4", int'(err_pulse), 1);
        chk("s35_st4", int'(state_o), 7);
        cyc(1'b1, 1'b0, P_OFF);

        // skipped step
        cyc(1'b1, 1'b1, P_OFF);
        chk("s36_clr_err", int'(err), 0);
        cyc(1'b1, 1'b0, P_L1); cyc(1'b1, 1'b0, P_L3);
        chk("s36_err", int'(err), 1);
        chk("s36_pulse", int'(err_pulse), 1);
        chk("s36_st", int'(state_o), 7);
        cyc(1'b1, 1'b0, P_L2);
        chk("s36_st_hold", int'(state_o), 7);
        chk("s36_no_pulse", int'(err_pulse), 0);
        cyc(1'b1, 1'b0, P_OFF);
        chk("s36_st_idle", int'(state_o), 0);
        chk("s36_err_sticky", int'(err), 1);

        // both sides lit, then clear
        cyc(1'b1, 1'b0, P_LR);
        chk("s37_st", int'(state_o), 7);
        cyc(1'b1, 1'b1, P_OFF);
        chk("s37_err", int'(err), 0);
        chk("s37_cnt", int'(left_cnt) + int'(right_cnt), 0);

        // narrow counter saturation
        for (int i = 0; i < 5; i++) begin
            left_seq();
            chk("s38_w2_lcnt", int'(b_left_cnt), (i < 3) ? i + 1 : 3);
        end

        // asynchronous reset mid-sequence
        cyc(1'b1, 1'b0, P_L1); cyc(1'b1, 1'b0, P_L2);
        chk("s39_st2", int'(state_o), 2);
        #2 reset = 1'b1;
        en = 1'b0;
        model_reset();
        #1;
        chk("s39_async_st", int'(state_o), 0);
        chk("s39_async_lon", int'(left_on), 0);
        chk("s39_async_cnt", int'(left_cnt), 0);
        @(negedge clk);
        reset = 1'b0;
        left_seq();
        chk("s39_lcnt", int'(left_cnt), 1);

        // clr coinciding with a violation, and en=0 holding state
        cyc(1'b1, 1'b1, P_LR);
        chk("clrviol_err", int'(err), 1);
        chk("clrviol_pulse", int'(err_pulse), 1);
        cyc(1'b1, 1'b0, P_OFF);
        cyc(1'b1, 1'b0, P_L1);
        cyc(1'b0, 1'b0, P_R3);
        chk("en0_hold", int'(state_o), 1);
        cyc(1'b0, 1'b1, P_R3);
        chk("en0_clr_st", int'(state_o), 1);
        cyc(1'b1, 1'b0, P_L2); cyc(1'b1, 1'b0, P_L3);
        cyc(1'b1, 1'b1, P_OFF);
        chk("clr_inc_lcnt", int'(left_cnt), 0);

        // full-width saturation
        for (int i = 0; i < 256; i++) left_seq();
        chk("sat8_lcnt", int'(left_cnt), 255);

        // biased random traffic
        prev = P_OFF;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60) begin
                if (m_mode == 0) p = lvl_pat(int'($urandom_range(1, 2)), 1);
                else if (m_mode == 1) p = (m_step == 3) ? P_OFF : lvl_pat(m_side, m_step + 1);
                else p = P_OFF;
            end else if (r < 85) begin
                p = prev;
            end else begin
                p = 6'($urandom);
            end
            cyc(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, p);
            prev = p;
        end

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/taillight_decoder.md
TAILLIGHT_DECODER -- requirements
Module: taillight_decoder

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 3, the maximum number of consecutive samples one light pattern may persist in a non-IDLE state.
REQ-002 The block SHALL have parameter CNT_W, default 8, the width of the sequence counters.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL be updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous and active-high.
REQ-005 The block SHALL have port en, input, 1 bit, the sample strobe; lamp inputs SHALL be evaluated only on cycles where en=1.
REQ-006 The block SHALL have port clr, input, 1 bit, a synchronous clear of err, left_cnt and right_cnt.
REQ-007 The block SHALL have ports la, lb, lc, ra, rb, rc, each an input of 1 bit, the observed tail-light lamps (left inner to outer, right inner to outer).
REQ-008 The block SHALL have ports left_on and right_on, each an output of 1 bit, asserted while a left or right sequence is in progress, respectively.
REQ-009 The block SHALL have port err, output, 1 bit, a sticky error flag.
REQ-010 The block SHALL have port err_pulse, output, 1 bit, a one-cycle pulse on each detected violation.
REQ-011 The block SHALL have ports left_cnt and right_cnt, each an output of CNT_W bits, counting completed left and right sequences.
REQ-012 The block SHALL have port state_o, output, 3 bits, the current decoder state.

Function
REQ-013 The block SHALL classify each sample as OFF (all 0), L1 (la), L2 (la,lb), L3 (la,lb,lc), R1 (ra), R2 (ra,rb), R3 (ra,rb,rc) or BAD (any other combination, including both sides lit).
REQ-014 The block SHALL implement the states IDLE=0, S_L1=1, S_L2=2, S_L3=3, S_R1=4, S_R2=5, S_R3=6 and S_ERR=7, driven on state_o.
REQ-015 The block SHALL hold all state and counters when en=0, except for clr.
REQ-016 In IDLE, the block SHALL stay in IDLE on OFF, go to S_L1 on L1, go to S_R1 on R1, and treat any other sample as a violation.
REQ-017 The block SHALL make the following legal advances: S_L1->S_L2 on L2, S_L2->S_L3 on L3, S_L3->IDLE on OFF, and the corresponding S_R1->S_R2->S_R3->IDLE on R2, R3 and OFF.
REQ-018 In S_Lx or S_Rx, a sample equal to the current pattern SHALL be a repeat, with the state held and the hold counter incremented.
REQ-019 The block SHALL clear the hold counter on every state change and in IDLE.
REQ-020 A repeat that would make the consecutive-sample count exceed HOLD_MAX SHALL be a violation.
REQ-021 In S_Lx or S_Rx, any sample that is neither a legal advance nor a repeat SHALL be a violation, including a skipped step, reversed order, a side switch or BAD.
REQ-022 On a violation, the block SHALL go to S_ERR, set err=1 and pulse err_pulse=1 for exactly one cycle.
REQ-023 In S_ERR, the block SHALL return to IDLE on OFF and stay in S_ERR on any other sample without further err_pulse.
REQ-024 The S_L3->IDLE transition on OFF SHALL increment left_cnt, and S_R3->IDLE on OFF SHALL increment right_cnt.
REQ-025 left_cnt and right_cnt SHALL saturate at 2^CNT_W-1 with no wrap-around.
REQ-026 left_on SHALL be 1 in S_L1 to S_L3 and right_on SHALL be 1 in S_R1 to S_R3; both SHALL be 0 in IDLE and S_ERR.
REQ-027 All outputs SHALL be registered, with a one-cycle latency from the clk edge sampling en=1 to the updated outputs.
REQ-028 clr=1 SHALL clear err, left_cnt and right_cnt on the next edge without changing state.
REQ-029 When clr coincides with a violation, err SHALL end at 1 and err_pulse SHALL still fire.
REQ-030 When clr coincides with a counter increment, the counter SHALL end at 0.

Reset
REQ-031 reset=1 SHALL asynchronously force IDLE, hold counter 0, left_on=0, right_on=0, err=0, err_pulse=0, left_cnt=0, right_cnt=0 and state_o=0.
REQ-032 A reset asserted mid-sequence SHALL abandon the sequence with no counter increment and no error.
REQ-033 After reset deasserts, the first en=1 sample SHALL be decoded from IDLE.

Verification
REQ-034 Scenario: en=1 every cycle, samples OFF, L1, L2, L3, OFF -> state_o 0,1,2,3,0; left_on high for 3 cycles; left_cnt=1; err=0.
REQ-035 Scenario: samples R1, R1, R1, R2, R3, OFF with HOLD_MAX=3 -> no error; right_cnt=1. Samples R1 x4 -> err_pulse on the 4th sample and state_o=7.
REQ-036 Scenario: samples L1, L3 (skipped step) -> err=1, err_pulse for one cycle, state_o=7. Then samples L2, OFF -> state_o stays 7, then returns to 0, with err still 1.
REQ-037 Scenario: from IDLE, sample la=1 and ra=1 (BAD) -> violation; then clr=1 with OFF -> err=0 and counters=0.
REQ-038 Scenario: CNT_W=2 with 5 full left sequences -> left_cnt counts 1,2,3,3,3.
REQ-039 Scenario: reset asserted while in S_L2 -> all outputs 0 immediately, without waiting for a clk edge; then L1, L2, L3, OFF -> left_cnt=1.
